bcd_multiword_sub_seq: RTL and testbench
========================================

Name: bcd_multiword_sub_seq

Overview:
- Sequences a long BCD subtraction, A − B, through one shared pipelined N-digit BCD subtractor instance that sits outside this block.
- Operands are M words long. Words are issued least-significant first.
- The borrow-out of each word feeds the borrow-in of the next word, so each word must wait the full pipeline latency before the next one issues.
- Sits between the decimal FPU mantissa stage and the subtractor; produces the result words plus sign/zero status.

Parameters:
WBITS, 264, word width in bits (8 bits = 2 BCD digits per byte lane); must match the subtractor width.
MAXW, 16, maximum number of words per operation.
LAT, 3, subtractor latency in clocks from inputs to valid sub_o/sub_co; must be ≥ 1.
IW, $clog2(MAXW+1), width of the word-count and word-index fields.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin an operation; sampled only in IDLE.
abort  in  1  synchronous cancel; returns to IDLE, no done.
nwords  in  IW  word count, sampled with start; range 0..MAXW.
busy  out  1  high in ISSUE and WAIT.
done  out  1  one-cycle pulse when the operation completes.
borrow  out  1  final borrow-out (1 = A < B, result is the 10's complement); held until the next start.
zero  out  1  all result words are zero; held until the next start.
op_idx  out  IW  index of the operand word being read.
op_a  in  WBITS  word op_idx of A (combinational read, same cycle).
op_b  in  WBITS  word op_idx of B.
sub_a  out  WBITS  subtractor A input.
sub_b  out  WBITS  subtractor B input.
sub_ci  out  1  subtractor borrow-in.
sub_o  in  WBITS  subtractor difference.
sub_co  in  1  subtractor borrow-out.
res_we  out  1  result write strobe.
res_idx  out  IW  result word index.
res_word  out  WBITS  result word, equal to sub_o.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy, done, borrow and res_we go to 0; zero goes to 1.
  - op_idx, res_idx, sub_a, sub_b and sub_ci go to 0.
  - The internal index, count, timer and borrow registers clear.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - start=1 with nwords≥1: latch count=nwords, idx=0, borrow_r=0, zero_acc=1; go to ISSUE.
  - start=1 with nwords=0: go to FIN with borrow=0, zero=1; no res_we.
  - nwords>MAXW is clamped to MAXW.
- ISSUE (exactly 1 cycle):
  - op_idx=idx; sub_a=op_a, sub_b=op_b, sub_ci=borrow_r.
  - Load timer=LAT, then go to WAIT.
  - Outside ISSUE, sub_a/sub_b/sub_ci are driven 0.
- WAIT:
  - Decrement timer each cycle.
  - Capture cycle = the ISSUE cycle + LAT. In that cycle, res_we=1, res_idx=idx, res_word=sub_o.
  - On the closing edge of the capture cycle: borrow_r←sub_co; zero_acc←zero_acc & (sub_o==0).
  - If idx==count−1, go to FIN; otherwise idx←idx+1 and go to ISSUE.
- Throughput: LAT+1 cycles per word. Total from start edge to done = nwords·(LAT+1)+1 cycles.
- FIN (1 cycle): done=1; borrow←borrow_r; zero←zero_acc; go to IDLE.
- borrow and zero are updated only in FIN and are stable at all other times.
- Busy rules: start is ignored in ISSUE, WAIT and FIN. nwords is not re-sampled mid-operation.
- Abort:
  - abort=1 in any non-IDLE state goes to IDLE on the next edge.
  - No done, no further res_we; borrow and zero keep their previous values.
  - A capture strobe coinciding with abort is still emitted that cycle; the completing result is not suppressed.
  - abort has priority over FIN: no done pulse.
- The subtractor is assumed free-running and unstalled. The block never overlaps two words in flight.
- Reset mid-operation: immediate return to IDLE. Partially written results are undefined; the caller restarts.

Test Plan:
All tests use WBITS=16 (4 digits/word), LAT=3, MAXW=4. In each multi-word operand, the value left of "_" is word 1 and the value right of "_" is word 0.
- Single word: start in cycle 0 with nwords=1, A=0x1234, B=0x0234 → res_we in cycle 4 with res_idx=0, res_word=0x1000; done in cycle 5; borrow=0, zero=0.
- Borrow chain: nwords=2, A=0x0001_0000, B=0x0000_0001 → word0=0x9999 with sub_ci=0; word1 issued with sub_ci=1 gives 0x0000; done in cycle 9; borrow=0, zero=0.
- Negative result: nwords=1, A=0x0000, B=0x0001 → res_word=0x9999, borrow=1. Then nwords=1, A=B=0x4321 → 0x0000, zero=1, borrow=0.
- nwords=0 → done one cycle after start; no res_we; zero=1, borrow=0. In another run, start pulsed while busy → ignored; op_idx sequence is unchanged.
- abort asserted in the WAIT of word 1 of a 3-word op → no done, no res_we for words 1 and 2; back in IDLE next cycle; a new start works normally.
- rst_n pulled low mid-WAIT → all outputs at reset values asynchronously; after release, a 1-word op completes with correct timing.

Source files
------------

// File: rtl/bcd_multiword_sub_seq_if.sv
//==============================================================================
// Module      : bcd_multiword_sub_seq_if
// Description : Control, operand-read, subtractor and result-write signals
//               of the multi-word BCD subtraction sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bcd_multiword_sub_seq_if #(
    parameter int WBITS = 264,
    parameter int IW    = 5
);
    logic             start;
    logic             abort;
    logic [IW-1:0]    nwords;
    logic             busy;
    logic             done;
    logic             borrow;
    logic             zero;
    logic [IW-1:0]    op_idx;
    logic [WBITS-1:0] op_a;
    logic [WBITS-1:0] op_b;
    logic [WBITS-1:0] sub_a;
    logic [WBITS-1:0] sub_b;
    logic             sub_ci;
    logic [WBITS-1:0] sub_o;
    logic             sub_co;
    logic             res_we;
    logic [IW-1:0]    res_idx;
    logic [WBITS-1:0] res_word;

    // Sequencer side
    modport slave (
        input  start, abort, nwords, op_a, op_b, sub_o, sub_co,
        output busy, done, borrow, zero, op_idx, sub_a, sub_b, sub_ci,
               res_we, res_idx, res_word
    );

    // Environment side: controller, operand store, subtractor, result store
    modport master (
        output start, abort, nwords, op_a, op_b, sub_o, sub_co,
        input  busy, done, borrow, zero, op_idx, sub_a, sub_b, sub_ci,
               res_we, res_idx, res_word
    );
endinterface

`default_nettype wire

// File: rtl/bcd_multiword_sub_seq.sv
//==============================================================================
// Module      : bcd_multiword_sub_seq
// Description : Chains a long BCD subtraction A - B word by word through one
//               shared pipelined subtractor, rippling the borrow between words.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_multiword_sub_seq #(
    parameter int WBITS = 264,
    parameter int MAXW  = 16,
    parameter int LAT   = 3,
    parameter int IW    = $clog2(MAXW + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bcd_multiword_sub_seq_if.slave  bus
);

    localparam int            TW     = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [TW-1:0] c_lat  = TW'(LAT);
    localparam logic [TW-1:0] c_one  = TW'(1);
    localparam logic [IW-1:0] c_maxw = IW'(MAXW);
    localparam logic [IW-1:0] c_ione = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_count;
    logic [TW-1:0] r_timer;
    logic          r_borrow_acc;
    logic          r_zero_acc;
    logic          r_borrow;
    logic          r_zero;

    logic [IW-1:0] w_nwords_clamped;
    logic          w_start_ok;
    logic          w_abort_ok;
    logic          w_issue;
    logic          w_capture;
    logic          w_last;
    logic          w_busy;
    logic          w_done;
    logic          w_word_zero;

    assign w_nwords_clamped = (bus.nwords > c_maxw) ? c_maxw : bus.nwords;
    assign w_last           = (r_idx == (r_count - c_ione));
    assign w_word_zero      = (bus.sub_o == '0);
    assign w_start_ok       = (r_state == ST_IDLE) && bus.start;
    assign w_abort_ok       = (r_state != ST_IDLE) && bus.abort;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and state-decoded strobes
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (w_nwords_clamped == '0) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                // Timer reaches 1 exactly LAT cycles after the issue cycle
                if (r_timer == c_one) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_last ? ST_FIN : ST_ISSUE;
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A capture coinciding with abort still strobes; only the done pulse
        // and the onward sequencing are cancelled.
        if (w_abort_ok) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Word index, count, latency timer and running borrow/zero accumulators
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_borrow_acc <= 1'b0;
            r_zero_acc   <= 1'b1;
        end else begin
            if (w_start_ok) begin
                r_idx        <= '0;
                r_count      <= w_nwords_clamped;
                r_borrow_acc <= 1'b0;
                r_zero_acc   <= 1'b1;
            end
            if (w_issue) begin
                r_timer <= c_lat;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer - c_one;
            end
            if (w_capture) begin
                r_borrow_acc <= bus.sub_co;
                r_zero_acc   <= r_zero_acc & w_word_zero;
                if (!w_last) begin
                    r_idx <= r_idx + c_ione;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Published status: changes only when an operation completes cleanly
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_borrow <= 1'b0;
            r_zero   <= 1'b1;
        end else if (w_done) begin
            r_borrow <= r_borrow_acc;
            r_zero   <= r_zero_acc;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.borrow   = r_borrow;
    assign bus.zero     = r_zero;
    assign bus.op_idx   = r_idx;
    assign bus.sub_a    = w_issue ? bus.op_a : '0;
    assign bus.sub_b    = w_issue ? bus.op_b : '0;
    assign bus.sub_ci   = w_issue & r_borrow_acc;
    assign bus.res_we   = w_capture;
    assign bus.res_idx  = r_idx;
    assign bus.res_word = bus.sub_o;

endmodule

`default_nettype wire

// File: tb/tb_bcd_multiword_sub_seq.sv
//==============================================================================
// Module      : tb_bcd_multiword_sub_seq
// Description : Directed scoreboard bench for bcd_multiword_sub_seq with a
//               behavioural 3-stage BCD subtractor (16-bit words, MAXW=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_multiword_sub_seq;

    localparam int WBITS = 16;
    localparam int MAXW  = 4;
    localparam int LAT   = 3;
    localparam int IW    = 3;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] word;
        logic        ci;
    } res_t;

    typedef struct {
        int   cyc;
        logic borrow;
        logic zero;
    } done_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   s0;
    int   n_chk;
    int   n_fail;

    res_t  qres[$];
    done_t qdone[$];

    logic [15:0] mem_a [4];
    logic [15:0] mem_b [4];
    logic [15:0] exp_w [4];
    logic        exp_ci[4];

    logic [16:0]   p1, p2, p3;
    logic [IW-1:0] ix1, ix2, ix3;
    logic          c1, c2, c3;

    bcd_multiword_sub_seq_if #(.WBITS(WBITS), .IW(IW)) intf ();

    bcd_multiword_sub_seq #(
        .WBITS (WBITS),
        .MAXW  (MAXW),
        .LAT   (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] bcd_sub(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci);
        logic [15:0] r;
        int          br;
        int          d;
        br = int'(ci);
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            d = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - br;
            if (d < 0) begin
                d  = d + 10;
                br = 1;
            end else begin
                br = 0;
            end
            r[4*i +: 4] = d[3:0];
        end
        return {(br != 0), r};
    endfunction

    // Free-running subtractor; also delays op_idx/sub_ci so the monitor can
    // see what was presented at issue time.
    always @(posedge clk) begin
        p1  <= bcd_sub(intf.sub_a, intf.sub_b, intf.sub_ci);
        p2  <= p1;
        p3  <= p2;
        ix1 <= intf.op_idx;
        ix2 <= ix1;
        ix3 <= ix2;
        c1  <= intf.sub_ci;
        c2  <= c1;
        c3  <= c2;
    end

    assign intf.sub_o  = p3[15:0];
    assign intf.sub_co = p3[16];
    assign intf.op_a   = (intf.op_idx < 3'd4) ? mem_a[intf.op_idx[1:0]] : 16'h0;
    assign intf.op_b   = (intf.op_idx < 3'd4) ? mem_b[intf.op_idx[1:0]] : 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected results/completions whenever the DUT presents one
    initial begin
        res_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (intf.res_we) begin
                    if (qres.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_res_we: got idx %0d word %0h, expected none (cycle %0d)",
                                 intf.res_idx, intf.res_word, cyc);
                    end else begin
                        r = qres.pop_front();
                        chk("res_cycle",  cyc, r.cyc);
                        chk("res_idx",    32'(intf.res_idx), r.idx);
                        chk("res_word",   32'(intf.res_word), 32'(r.word));
                        chk("issue_op_idx", 32'(ix3), r.idx);
                        chk("issue_sub_ci", 32'(c3), 32'(r.ci));
                    end
                end
                if (intf.done) begin
                    if (qdone.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        d = qdone.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        @(negedge clk);
                        chk("borrow", 32'(intf.borrow), 32'(d.borrow));
                        chk("zero",   32'(intf.zero),   32'(d.zero));
                    end
                end
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts an operation in the current cycle and queues its expectations
    task automatic launch(input int n, input int nres, input logic eb, input logic ez,
                          input bit exp_done);
        res_t  r;
        done_t d;
        int    ne;
        ne = (n > MAXW) ? MAXW : n;
        s0 = cyc;
        for (int i = 0; i < nres; i++) begin
            r.cyc  = s0 + (LAT + 1) * (i + 1);
            r.idx  = i;
            r.word = exp_w[i];
            r.ci   = exp_ci[i];
            qres.push_back(r);
        end
        if (exp_done) begin
            d.cyc    = s0 + (LAT + 1) * ne + 1;
            d.borrow = eb;
            d.zero   = ez;
            qdone.push_back(d);
        end
        intf.nwords = IW'(n);
        intf.start  = 1'b1;
        @(posedge clk);
        #1;
        intf.start  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((qres.size() != 0 || qdone.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (qres.size() != 0 || qdone.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: got %0d results and %0d completions outstanding, expected 0",
                     qres.size(), qdone.size());
            qres.delete();
            qdone.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},    32'(intf.busy),    0);
        chk({tag, "_done"},    32'(intf.done),    0);
        chk({tag, "_borrow"},  32'(intf.borrow),  0);
        chk({tag, "_zero"},    32'(intf.zero),    1);
        chk({tag, "_res_we"},  32'(intf.res_we),  0);
        chk({tag, "_op_idx"},  32'(intf.op_idx),  0);
        chk({tag, "_res_idx"}, 32'(intf.res_idx), 0);
        chk({tag, "_sub_a"},   32'(intf.sub_a),   0);
        chk({tag, "_sub_b"},   32'(intf.sub_b),   0);
        chk({tag, "_sub_ci"},  32'(intf.sub_ci),  0);
    endtask

    task automatic set_word(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] w, input logic ci);
        mem_a[i]  = a;
        mem_b[i]  = b;
        exp_w[i]  = w;
        exp_ci[i] = ci;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        intf.start  = 1'b0;
        intf.abort  = 1'b0;
        intf.nwords = '0;
        for (int i = 0; i < 4; i++) set_word(i, 16'h0, 16'h0, 16'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word
        set_word(0, 16'h1234, 16'h0234, 16'h1000, 1'b0);
        launch(1, 1, 1'b0, 1'b0, 1'b1);
        drain();

        // Borrow ripples from word 0 into word 1
        set_word(0, 16'h0000, 16'h0001, 16'h9999, 1'b0);
        set_word(1, 16'h0001, 16'h0000, 16'h0000, 1'b1);
        launch(2, 2, 1'b0, 1'b0, 1'b1);
        drain();

        // Negative result, then equal operands
        set_word(0, 16'h0000, 16'h0001, 16'h9999, 1'b0);
        launch(1, 1, 1'b1, 1'b0, 1'b1);
        drain();
        set_word(0, 16'h4321, 16'h4321, 16'h0000, 1'b0);
        launch(1, 1, 1'b0, 1'b1, 1'b1);
        drain();

        // Leave borrow=1 so the zero-length op visibly restores defaults
        set_word(0, 16'h0000, 16'h0001, 16'h9999, 1'b0);
        launch(1, 1, 1'b1, 1'b0, 1'b1);
        drain();
        launch(0, 0, 1'b0, 1'b1, 1'b1);
        drain();

        // Start pulses while busy (WAIT and FIN) are ignored
        set_word(0, 16'h1111, 16'h2222, 16'h8889, 1'b0);
        set_word(1, 16'h5678, 16'h1234, 16'h4443, 1'b1);
        launch(2, 2, 1'b0, 1'b0, 1'b1);
        go_to(s0 + 3);
        intf.nwords = 3'd1;
        intf.start  = 1'b1;
        @(posedge clk);
        #1;
        intf.start  = 1'b0;
        go_to(s0 + 9);
        intf.start  = 1'b1;
        @(posedge clk);
        #1;
        intf.start  = 1'b0;
        drain();

        // nwords above MAXW is clamped
        for (int i = 0; i < 4; i++) set_word(i, 16'h1111, 16'h0000, 16'h1111, 1'b0);
        launch(5, 4, 1'b0, 1'b0, 1'b1);
        drain();

        // Abort during the WAIT of word 1 of a 3-word op
        for (int i = 0; i < 3; i++) set_word(i, 16'h0005, 16'h0002, 16'h0003, 1'b0);
        launch(3, 1, 1'b0, 1'b0, 1'b0);
        go_to(s0 + 6);
        intf.abort = 1'b1;
        @(posedge clk);
        #1;
        intf.abort = 1'b0;
        chk("abort_idle_busy", 32'(intf.busy), 0);
        drain();
        chk("abort_borrow_kept", 32'(intf.borrow), 0);
        chk("abort_zero_kept",   32'(intf.zero),   0);
        set_word(0, 16'h0000, 16'h0001, 16'h9999, 1'b0);
        launch(1, 1, 1'b1, 1'b0, 1'b1);
        drain();

        // Asynchronous reset mid-WAIT, then a clean single-word op
        set_word(0, 16'h2000, 16'h1000, 16'h1000, 1'b0);
        set_word(1, 16'h2000, 16'h1000, 16'h1000, 1'b0);
        launch(2, 0, 1'b0, 1'b0, 1'b0);
        go_to(s0 + 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        qres.delete();
        qdone.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_word(0, 16'h9999, 16'h0001, 16'h9998, 1'b0);
        launch(1, 1, 1'b0, 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
